// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: consumes WIDTH bit pairs MSB first and
// reports A<B / A==B / A>B with a one-cycle done pulse.
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic                         a_bit,
    input  logic                         b_bit,
    output logic                         busy,
    output logic                         done,
    output logic                         smaller,
    output logic                         equal,
    output logic                         greater,
    output logic [$clog2(WIDTH+1)-1:0]   bit_count,
    output logic [1:0]                   fsm_state
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] COMPARE = 2'b01;
    localparam logic [1:0] DONE    = 2'b10;

    localparam logic [1:0] REL_EQ = 2'b00;
    localparam logic [1:0] REL_LT = 2'b01;
    localparam logic [1:0] REL_GT = 2'b10;

    localparam logic [CW-1:0] LAST = CW'(WIDTH);

    logic [1:0] state;
    logic [1:0] rel;

    // Handshake: a bit pair is consumed on a rising edge in COMPARE when
    // in_valid=1 and fewer than WIDTH pairs have been taken; there is no ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rel       <= REL_EQ;
            bit_count <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            smaller   <= 1'b0;
            equal     <= 1'b0;
            greater   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= COMPARE;
                        rel       <= REL_EQ;
                        bit_count <= '0;
                        busy      <= 1'b1;
                        smaller   <= 1'b0;
                        equal     <= 1'b0;
                        greater   <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (bit_count == LAST) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        smaller <= (rel == REL_LT);
                        equal   <= (rel == REL_EQ);
                        greater <= (rel == REL_GT);
                    end else if (in_valid) begin
                        bit_count <= bit_count + CW'(1);
                        // The first differing bit decides; afterwards the relation is locked.
                        if (rel == REL_EQ && a_bit != b_bit) begin
                            rel <= a_bit ? REL_GT : REL_LT;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator (WIDTH=8 main instance, WIDTH=1 corner instance).
module tb_serial_comparator;

    logic       clk = 1'b0;
    logic       rst, start, in_valid, a_bit, b_bit;
    logic       busy, done, smaller, equal, greater;
    logic [3:0] bit_count;
    logic [1:0] fsm_state;

    logic       start1, in_valid1, a1, b1;
    logic       busy1, done1, smaller1, equal1, greater1;
    logic       bit_count1;
    logic [1:0] fsm_state1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_pulses = 0;

    serial_comparator #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
        .smaller(smaller), .equal(equal), .greater(greater),
        .bit_count(bit_count), .fsm_state(fsm_state)
    );

    serial_comparator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1),
        .a_bit(a1), .b_bit(b1), .busy(busy1), .done(done1),
        .smaller(smaller1), .equal(equal1), .greater(greater1),
        .bit_count(bit_count1), .fsm_state(fsm_state1)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Result flags: one-hot while done, all clear during COMPARE.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_pulses++;
            check_eq("onehot_at_done", $countones({smaller, equal, greater}), 1);
        end else if (busy === 1'b1) begin
            check_eq("flags_clear_in_compare", {29'd0, smaller, equal, greater}, 0);
        end
    end

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_done_seen"}, done, 1);
    endtask

    task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input int stall_after, input int stall_len,
                           input logic [2:0] exp_seg, input int exp_lat);
        int c0;
        start = 1'b1;
        tick();
        start = 1'b0;
        c0 = cyc;
        check_eq({tag, "_count_start"}, bit_count, 0);
        check_eq({tag, "_busy"}, busy, 1);
        for (int i = 0; i < 8; i++) begin
            if (i == stall_after) begin
                in_valid = 1'b0;
                a_bit = ~a[7-i];
                b_bit = a[7-i];
                repeat (stall_len) tick();
            end
            in_valid = 1'b1;
            a_bit = a[7-i];
            b_bit = b[7-i];
            tick();
        end
        in_valid = 1'b0;
        check_eq({tag, "_no_early_done"}, done, 0);
        wait_done(tag);
        check_eq({tag, "_latency"}, cyc - c0, exp_lat);
        check_eq({tag, "_seg"}, {smaller, equal, greater}, exp_seg);
        check_eq({tag, "_count_done"}, bit_count, 8);
        tick();
        check_eq({tag, "_done_pulse"}, done, 0);
        check_eq({tag, "_idle"}, busy, 0);
        check_eq({tag, "_seg_hold"}, {smaller, equal, greater}, exp_seg);
        check_eq({tag, "_count_hold"}, bit_count, 8);
    endtask

    initial begin
        logic [7:0] ta;
        logic [7:0] tb;
        int d0;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
        tick();
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        check_eq("reset_state", fsm_state, 0);
        check_eq("reset_outs", {busy, done, smaller, equal, greater, bit_count}, 0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;

        run_cmp("eq_a5", 8'hA5, 8'hA5, 99, 0, 3'b010, 9);
        run_cmp("gt_80_7f", 8'h80, 8'h7F, 99, 0, 3'b001, 9);
        run_cmp("lt_stall", 8'h3C, 8'h3D, 4, 3, 3'b100, 12);

        // Abort mid-comparison with reset; no done may follow.
        ta = 8'hAA; tb = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; a_bit = ta[7-i]; b_bit = tb[7-i];
            tick();
        end
        check_eq("abort_count4", bit_count, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_state", fsm_state, 0);
        check_eq("abort_outs", {busy, done, smaller, equal, greater, bit_count}, 0);
        d0 = done_pulses;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            a_bit = 1'($urandom_range(0, 1));
            b_bit = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        check_eq("abort_no_done", done_pulses, d0);
        check_eq("abort_stays_idle", busy, 0);
        run_cmp("gt_ff_00", 8'hFF, 8'h00, 99, 0, 3'b001, 9);

        // start+in_valid in IDLE: pair not consumed; start in COMPARE/DONE ignored.
        ta = 8'h0F; tb = 8'hF0;
        start = 1'b1; in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
        tick();
        start = 1'b0; in_valid = 1'b0;
        check_eq("idle_pair_ignored", bit_count, 0);
        check_eq("idle_start_busy", busy, 1);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a_bit = ta[7-i]; b_bit = tb[7-i];
            start = (i == 3);
            tick();
            if (i == 3) check_eq("start_in_compare_ignored", bit_count, 4);
        end
        start = 1'b0; in_valid = 1'b0;
        wait_done("restart");
        check_eq("restart_seg", {smaller, equal, greater}, 3'b100);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_in_done_ignored", busy, 0);
        tick();
        check_eq("still_idle", fsm_state, 0);

        // Reset wins over start.
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check_eq("rst_over_start", busy, 0);

        // WIDTH=1: one pair completes the comparison.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        in_valid1 = 1'b1; a1 = 1'b0; b1 = 1'b1;
        tick();
        in_valid1 = 1'b0;
        check_eq("w1_count", bit_count1, 1);
        check_eq("w1_no_done_yet", done1, 0);
        tick();
        check_eq("w1_done", done1, 1);
        check_eq("w1_seg", {smaller1, equal1, greater1}, 3'b100);
        tick();
        check_eq("w1_idle", {busy1, done1}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the operand length in bits (legal range 1 to 32).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have port clk, input, 1 bit, meaning the system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, meaning the synchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, meaning a request to begin a new comparison.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning a_bit and b_bit carry a valid bit pair this cycle.
REQ-007 SHALL have port a_bit, input, 1 bit, meaning the current bit of operand A, MSB first.
REQ-008 SHALL have port b_bit, input, 1 bit, meaning the current bit of operand B, MSB first.
REQ-009 SHALL have port busy, output, 1 bit, meaning a comparison is in progress.
REQ-010 SHALL have port done, output, 1 bit, meaning a one-cycle pulse that the result is valid.
REQ-011 SHALL have port smaller, output, 1 bit, meaning A < B.
REQ-012 SHALL have port equal, output, 1 bit, meaning A == B.
REQ-013 SHALL have port greater, output, 1 bit, meaning A > B.
REQ-014 SHALL have port bit_count, output, $clog2(WIDTH+1) bits, meaning the number of bit pairs consumed in the current comparison.

Function
REQ-015 SHALL implement an FSM with states IDLE, COMPARE and DONE, encoded as two bits.
REQ-016 IDLE: start=1 SHALL move the FSM to COMPARE, clear bit_count to 0, set the internal relation to EQ and clear smaller, equal and greater to 0.
REQ-017 IDLE: in_valid SHALL be ignored; when start and in_valid are both 1, the bit pair SHALL NOT be consumed.
REQ-018 COMPARE: each cycle with in_valid=1 SHALL consume one bit pair and increment bit_count by 1.
REQ-019 COMPARE: with relation EQ, a_bit=1/b_bit=0 SHALL set the relation to GT, a_bit=0/b_bit=1 SHALL set it to LT, and equal bits SHALL leave it at EQ.
REQ-020 COMPARE: once the relation is LT or GT, it SHALL be locked; later bit pairs SHALL still be counted but SHALL NOT alter the relation.
REQ-021 COMPARE: in_valid=0 SHALL stall, with no change to bit_count or the relation (no timeout).
REQ-022 COMPARE: when the WIDTH-th valid bit pair is consumed, the FSM SHALL move to DONE on the next edge.
REQ-023 DONE: the FSM SHALL hold for exactly one cycle, asserting done=1 with smaller/equal/greater driven from the relation (exactly one high), then return to IDLE.
REQ-024 Latency: done SHALL rise exactly 1 cycle after the edge that consumes the final bit pair.
REQ-025 smaller, equal and greater SHALL hold their value after DONE until the next accepted start or reset.
REQ-026 busy SHALL be 1 in COMPARE and DONE, and 0 in IDLE.
REQ-027 start SHALL be ignored in COMPARE and DONE (no abort, no restart).
REQ-028 bit_count SHALL hold WIDTH after DONE until the next accepted start.
REQ-029 For WIDTH=1: a single valid pair SHALL complete the comparison, with done one cycle later.
REQ-030 The block SHALL have no combinational path from inputs to outputs; all outputs SHALL be registered.

Reset
REQ-031 rst=1 SHALL force IDLE, busy=0, done=0, smaller=0, equal=0, greater=0, bit_count=0 and relation EQ on the next edge.
REQ-032 rst SHALL take priority over start and in_valid in every state.
REQ-033 rst asserted in COMPARE or DONE SHALL abort the comparison with no done pulse; the partial result SHALL be discarded.

Verification
REQ-034 WIDTH=8, A=0xA5, B=0xA5, in_valid held 1 -> done at cycle 9 after start, equal=1, smaller=0, greater=0, bit_count=8.
REQ-035 A=0x80, B=0x7F -> relation locks GT on the first bit; greater=1 and done one cycle after the 8th bit; the remaining 7 bits do not change it.
REQ-036 A=0x3C, B=0x3D with in_valid deasserted for 3 cycles mid-stream -> smaller=1, done delayed by exactly 3 cycles, bit_count=8.
REQ-037 rst pulsed after 4 bits of a comparison -> no done pulse; all outputs 0; a fresh start then compares 0xFF vs 0x00 -> greater=1.
REQ-038 start pulsed during COMPARE and start+in_valid in IDLE -> the first start is ignored; the IDLE pair is not counted (bit_count=0 the cycle after).
REQ-039 A bench SHALL check for all outputs that exactly one of smaller/equal/greater is high whenever done=1, and all three are 0 between start and done.
